// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared widths and FSM state type for the cacheline adaptor
package cacheline_adaptor_pkg;
  localparam int BEATS    = 4;
  localparam int BEAT_W   = 64;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int ADDR_W   = 32;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} cla_state_t;
endpackage

// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if: cache-side line port and memory-side burst port bundled together
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;
  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic [ADDR_W-1:0] address_i;
  logic [ADDR_W-1:0] address_o;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  logic [BEAT_W-1:0] burst_i;
  logic [BEAT_W-1:0] burst_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;
  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, address_o, resp_o, burst_o, read_o, write_o
  );
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, address_o, resp_o, burst_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: 256-bit single-cycle line transfers <-> 4-beat 64-bit memory bursts
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input logic               clk,
  input logic               rst,
  cacheline_adaptor_if.slave bus
);
  cla_state_t        state_q;
  logic [1:0]        k_q;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] wbuf_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              wr_q;
  logic              resp_q;
  assign bus.line_o    = line_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = rd_q;
  assign bus.write_o   = wr_q;
  assign bus.resp_o    = resp_q;
  assign bus.burst_o   = wbuf_q[{k_q, 6'd0} +: BEAT_W];
  // Read wins when the cache (illegally) raises both strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      line_q  <= '0;
      wbuf_q  <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.read_i || bus.write_i) begin
          state_q <= bus.read_i ? RD : WR;
          rd_q    <= bus.read_i;
          wr_q    <= !bus.read_i;
          k_q     <= '0;
          addr_q  <= bus.address_i & ~ADDR_W'(LINE_W / 8 - 1);
          if (!bus.read_i) wbuf_q <= bus.line_i;
        end
        RD, WR: if (bus.resp_i) begin
          if (state_q == RD) line_q[{k_q, 6'd0} +: BEAT_W] <= bus.burst_i;
          k_q <= k_q + 2'd1;
          if (k_q == 2'(BEATS - 1)) begin
            state_q <= DONE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b1;
          end
        end
        DONE: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed transfers with a queue scoreboard checked by a resp/beat monitor
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;
  typedef struct {
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t sbq[$];
  logic [63:0] wq[$];
  logic [255:0] last_rd = '0;
  localparam logic [255:0] R1 = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                                 64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
  localparam logic [255:0] R2 = {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                                 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};
  localparam logic [255:0] R3 = {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                                 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] R4 = {64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF,
                                 64'hFEDC_BA98_7654_3210, 64'h7FFF_FFFF_FFFF_FFFE};
  localparam logic [255:0] W1 = {64'hD, 64'hC, 64'hB, 64'hA};
  localparam logic [255:0] W2 = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                                 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
  localparam logic [255:0] W3 = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                                 64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};

  cacheline_adaptor_if bus();
  cacheline_adaptor dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(negedge clk);
    if (bus.write_o && bus.resp_i) begin
      if (wq.size() == 0) chk("unexpected_wbeat", bus.write_o, 0);
      else chk("wbeat", bus.burst_o, wq.pop_front());
    end
    if (bus.resp_o) begin
      if (sbq.size() == 0) chk("unexpected_resp", bus.resp_o, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_addr", bus.address_o, e.addr);
        chk("resp_line", bus.line_o, e.line);
      end
    end
  end

  // Issue one request; pat[c] is resp_i in the c-th cycle after acceptance, then 1s.
  task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [255:0] wl, input logic [255:0] rl,
                      input logic [15:0] pat, input int plen, input int exp_lat);
    int beat = 0;
    int lat = 0;
    bit got = 0;
    logic [255:0] exp_line;
    exp_line = rd ? rl : last_rd;
    sbq.push_back('{addr & 32'hFFFF_FFE0, exp_line});
    if (!rd) for (int i = 0; i < 4; i++) wq.push_back(wl[i*64 +: 64]);
    bus.address_i = addr;
    bus.line_i    = wl;
    bus.read_i    = rd;
    bus.write_i   = wr;
    tick;
    lat = 1;
    for (int c = 0; c < 40 && !got; c++) begin
      bus.resp_i  = c < plen ? pat[c] : 1'b1;
      bus.burst_i = rl[beat*64 +: 64];
      chk("active_req", rd ? bus.read_o : bus.write_o, 1);
      chk("other_req", rd ? bus.write_o : bus.read_o, 0);
      chk("no_early_resp", bus.resp_o, 0);
      if (!rd) begin
        chk("burst_o", bus.burst_o, wl[beat*64 +: 64]);
        chk("line_hold", bus.line_o, last_rd);
      end
      tick;
      lat++;
      if (bus.resp_i) beat++;
      got = bus.resp_o;
    end
    chk("resp_seen", bus.resp_o, 1);
    chk("latency", lat, exp_lat);
    chk("req_low_done", {bus.read_o, bus.write_o}, 0);
    bus.resp_i  = 1'b0;
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    if (rd) last_rd = rl;
    tick;
    chk("resp_single", bus.resp_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 0; bus.write_i = 0;
    bus.burst_i = '0; bus.resp_i = 0;
    tick;
    tick;
    chk("rst_outs", {bus.read_o, bus.write_o, bus.resp_o, bus.address_o, bus.burst_o}, 0);
    chk("rst_line", bus.line_o, 0);
    rst = 1'b0;
    tick;
    xfer(1, 0, 32'h1234_5678, '0, R1, 16'h0, 0, 5);
    chk("read1_line", bus.line_o, R1);
    chk("read1_addr", bus.address_o, 32'h1234_5660);
    xfer(0, 1, 32'hABCD_0047, W1, '0, 16'b1011001, 7, 8);
    xfer(1, 1, 32'h0000_103F, W2, R2, 16'h0, 0, 5);
    bus.address_i = 32'h5555_0020;
    bus.read_i    = 1'b1;
    tick;
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'h9999_9999_9999_9999;
    tick;
    bus.burst_i = 64'h8888_8888_8888_8888;
    tick;
    #2 rst = 1'b1;
    #1;
    chk("midrst_outs", {bus.read_o, bus.write_o, bus.resp_o, bus.address_o, bus.burst_o}, 0);
    chk("midrst_line", bus.line_o, 0);
    bus.read_i = 1'b0;
    bus.resp_i = 1'b0;
    tick;
    chk("rst_hold_resp", bus.resp_o, 0);
    #2 rst = 1'b0;
    last_rd = '0;
    tick;
    xfer(1, 0, 32'h0BAD_F00D, '0, R3, 16'b11011, 5, 6);
    bus.resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stray_idle", {bus.read_o, bus.write_o, bus.resp_o}, 0);
      chk("stray_line", bus.line_o, R3);
    end
    bus.resp_i = 1'b0;
    tick;
    xfer(0, 1, 32'h2000_0100, W2, '0, 16'h0, 0, 5);
    xfer(1, 0, 32'h7777_77E0, '0, R4, 16'h0, 0, 5);
    xfer(0, 1, 32'h7777_77E0, W3, '0, 16'b0101, 4, 7);
    chk("write_keeps_line", bus.line_o, R4);
    tick;
    chk("sb_drained", sbq.size(), 0);
    chk("wq_drained", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts single-cycle 256-bit cacheline transfers from the cache's physical-memory port into 4-beat 64-bit bursts on the main-memory bus, and the reverse. It sits directly downstream of the cache datapath/control pair. It consumes that pair's pmem_address, pmem_wdata and read/write strobes, and returns pmem_rdata and pmem_resp. One transfer is in flight at a time.

## Interface
- BEATS, 4: beats per line. Fixed, with BEATS × 64 = 256.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- line_i  in  256  write-back line from the cache (pmem_wdata).
- line_o  out  256  assembled fill line to the cache (pmem_rdata).
- address_i  in  32  line address from the cache (pmem_address).
- read_i  in  1  cache line-read request; held until resp_o.
- write_i  in  1  cache line-write request; held until resp_o.
- resp_o  out  1  one-cycle completion pulse (pmem_resp).
- burst_i  in  64  read beat from memory.
- burst_o  out  64  write beat to memory.
- address_o  out  32  burst address, {address_i[31:5], 5'b0}, latched at acceptance.
- read_o  out  1  memory burst-read request.
- write_o  out  1  memory burst-write request.
- resp_i  in  1  memory beat handshake; each high cycle completes one beat.

## Operation
- States:
  - IDLE: no transfer.
  - RD: beat counter active, reading.
  - WR: beat counter active, writing.
  - DONE: completion cycle.
- IDLE → RD when read_i = 1. IDLE → WR when write_i = 1 and read_i = 0.
  - read_i and write_i together is illegal from the cache; read wins.
  - Acceptance latches address_i into address_o. For WR, line_i is latched into an internal 256-bit write buffer.
- RD:
  - read_o = 1.
  - On each clk edge with resp_i = 1, burst_i is written into line buffer slice [64k +: 64], where k is the beat counter, and k increments.
  - When the edge samples resp_i with k = 3, go to DONE.
- WR:
  - write_o = 1 and burst_o = wbuf[64k +: 64].
  - On each edge with resp_i = 1, k increments. Beat 3 accepted → DONE.
- resp_i low stalls the burst: k holds and burst_o holds. Gaps between beats are legal.
- DONE: resp_o = 1 for exactly one cycle, read_o = write_o = 0, then → IDLE. Requests are not accepted in DONE.
- line_o is the line buffer. It changes only during RD beats and is stable from DONE until the next RD's first beat.
- resp_i is ignored in IDLE and DONE.
- k is 2 bits, cleared on acceptance. Wrap past 3 never occurs because the state leaves RD/WR at k = 3.

## Timing
- Reset (async, any state, mid-burst included): state = IDLE, k = 0, resp_o = 0, read_o = 0, write_o = 0, address_o = 0, line_o = 0, burst_o = 0, write buffer = 0.
  - A burst interrupted by reset is abandoned. No resp_o is issued.
- Request seen high at edge n (in IDLE) → read_o/write_o high from cycle n+1.
- Fourth resp_i sampled at edge m → resp_o high and read_o/write_o low during cycle m+1 → IDLE at m+2.
- Minimum latency, with memory answering beats on cycles n+1 to n+4: resp_o in cycle n+5. That is 5 cycles from request to resp_o.
- The cache may present a new request in the cycle after DONE. It is accepted in IDLE on that edge. Back-to-back throughput is one line per 6 cycles minimum.
- All outputs are registered or decoded from state only. There are no combinational paths from cache inputs to memory outputs.

## Structure
- Shared package (rv32i_types or a cache package): cla_state_t enum {IDLE, RD, WR, DONE}; localparams BEATS = 4, BEAT_W = 64, LINE_W = 256, OFFSET_W = 5.
- Single module. The beat counter, line buffer and write buffer are inline; no sub-module is warranted.

## Test plan
- Read, back-to-back beats: address_i = 0x1234_5678, read_i = 1; memory returns 0x0..0 through 0x3..3 with resp_i high 4 consecutive cycles.
  - Required: address_o = 0x1234_5660.
  - Required: line_o = {64'h3.., 64'h2.., 64'h1.., 64'h0..}.
  - Required: resp_o is a single pulse 5 cycles after the request.
- Write with stalls: line_i = {64'hD, 64'hC, 64'hB, 64'hA}; resp_i pattern 1,0,0,1,1,0,1.
  - Required: burst_o = A, B, B, B, C, D, D, with changes only after sampled resp_i.
  - Required: exactly one resp_o, after the 4th accepted beat.
- Simultaneous read_i = write_i = 1 → RD burst only; write_o stays 0.
- rst asserted after 2 read beats → all outputs 0 immediately; no resp_o. A new read then completes normally with fresh data.
- Stray resp_i in IDLE with no request → no state change and no resp_o. A subsequent write still takes exactly 4 beats.
- Read then write back-to-back (write_i asserted the cycle after DONE) → the write is accepted, and line_o retains the read line throughout the write.
